decryption_config_master: RTL and testbench
===========================================

// Module: decryption_config_master
// PURPOSE
// - Initiator side of the decryption register access interface: programs select, caesar, scytale and zigzag
//   keys into the decryption register file with single-cycle read/write strobes, tracking done/error.
// - Optional read-back verify of every register; reports pass/fail to the top-level controller.
// - Sits between the system controller (start + config values) and the register file bus.
// PARAMETERS
// - addr_width      8   bus address width
// - reg_width       16  bus data width
// - VERIFY          1   1 = read back and compare all four registers after writing; 0 = write only
// - TIMEOUT_CYCLES  15  max cycles waiting for done per access before abort (counter 4 bits, min 2)
// PORTS
// - clk          in   1           clock; all logic on posedge clk
// - rst          in   1           asynchronous, active-high reset
// - start        in   1           request a configuration sequence (sampled in IDLE only)
// - cfg_select   in   2           algorithm select to program
// - cfg_caesar   in   reg_width   caesar key
// - cfg_scytale  in   reg_width   scytale key
// - cfg_zigzag   in   reg_width   zigzag key
// - busy         out  1           sequence in progress
// - cfg_done     out  1           one-cycle pulse: sequence finished (success or fail)
// - cfg_fail     out  1           valid with cfg_done; held until next start
// - err_code     out  2           0 none, 1 bus error, 2 verify mismatch, 3 timeout; held until next start
// - err_index    out  2           register index of failure (0 select,1 caesar,2 scytale,3 zigzag)
// - addr         out  addr_width  bus address
// - read         out  1           bus read strobe
// - write        out  1           bus write strobe
// - wdata        out  reg_width   bus write data
// - rdata        in   reg_width   bus read data, valid in cycle done=1
// - done         in   1           bus access complete (one-cycle pulse)
// - error        in   1           bus access error (same cycle as done)
// BEHAVIOUR
// - Interface decided: one clock; reset is asynchronous and active-high.
// - Reset: all outputs 0 (addr, wdata, read, write, busy, cfg_done, cfg_fail, err_code, err_index); FSM -> IDLE.
//   Reset mid-sequence: strobes drop asynchronously, no further access issued, no cfg_done.
// - Register map: idx0 8'h00 (select, wdata={14'b0,cfg_select}), idx1 8'h10, idx2 8'h12, idx3 8'h14.
// - States: IDLE, ISSUE, WAIT, DONE.
//   IDLE: start=1 -> latch all cfg_* inputs, clear cfg_fail/err_code/err_index, idx=0, phase=WR, busy=1, -> ISSUE.
//   ISSUE: drive addr/wdata for idx, assert write (phase WR) or read (phase RD) for exactly 1 cycle;
//          clear timeout counter -> WAIT.
//   WAIT: read/write low, addr/wdata held. done=1: error=1 -> fail code 1; phase RD and rdata != expected
//         (idx0 compares rdata[1:0] only and requires rdata[15:2]==0) -> fail code 2; else advance.
//         Counter reaches TIMEOUT_CYCLES with no done -> fail code 3. Fail -> DONE with err_index=idx.
//   Advance: idx<3 -> idx+1, ISSUE. idx==3 and phase WR and VERIFY=1 -> phase RD, idx=0, ISSUE;
//            otherwise -> DONE.
//   DONE: cfg_done=1 for one cycle, busy=0 -> IDLE. cfg_fail = (err_code != 0).
// - Latency (responder done 1 cycle after strobe): 2 cycles per access; VERIFY=1 start->cfg_done = 17 cycles,
//   VERIFY=0 = 9 cycles.
// - Never asserts read and write together. start while busy is ignored; start in the DONE cycle is ignored.
// - done/error arriving outside WAIT are ignored. First failure aborts: remaining accesses not issued.
// - Latched config is used for whole sequence; cfg_* changes after start have no effect.
// STRUCTURE
// - Shared package decryption_pkg: register addresses (ADDR_SELECT 8'h00, ADDR_CAESAR 8'h10,
//   ADDR_SCYTALE 8'h12, ADDR_ZIGZAG 8'h14), reset key values, err_code encodings, FSM state encoding.
// - No sub-module: flat FSM + idx/phase registers + timeout counter; address/expected-data mux as a function.
// TESTING (bench pairs this block with the decryption register file)
// - start, select=2, caesar=16'h0003, scytale=16'h0404, zigzag=16'h0005, VERIFY=1 -> writes to 00,10,12,14
//   then reads same order; cfg_done 17 cycles after start, cfg_fail=0; regfile outputs hold programmed values.
// - Responder forced error=1 with done on idx2 write -> cfg_done, err_code=1, err_index=2, zigzag not written.
// - Responder returns rdata=16'h0007 on caesar read-back (expected 16'h0003) -> err_code=2, err_index=1.
// - Responder never asserts done on first access -> abort after TIMEOUT_CYCLES, err_code=3, err_index=0.
// - start pulses while busy and cfg_* change mid-sequence -> single sequence, original latched values written.
// - rst asserted during WAIT of idx1 -> read/write/busy 0 immediately; no cfg_done; new start runs cleanly.

Source files
------------

// File: rtl/decryption_pkg.sv
// Shared definitions for the decryption register access path.
// Register map, reset key values, error codes and config-master FSM encoding.
// Pure declarations; no logic, no latency.
package decryption_pkg;

  // Register file addresses, one per programmable key
  localparam logic [7:0] ADDR_SELECT  = 8'h00;
  localparam logic [7:0] ADDR_CAESAR  = 8'h10;
  localparam logic [7:0] ADDR_SCYTALE = 8'h12;
  localparam logic [7:0] ADDR_ZIGZAG  = 8'h14;

  // Values the register file comes out of reset with
  localparam logic [1:0]  RST_SELECT  = 2'd0;
  localparam logic [15:0] RST_CAESAR  = 16'h0000;
  localparam logic [15:0] RST_SCYTALE = 16'hFFFF;
  localparam logic [15:0] RST_ZIGZAG  = 16'h0002;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BUS     = 2'd1,
    ERR_VERIFY  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    PH_WR = 1'b0,
    PH_RD = 1'b1
  } phase_t;

  // Register index (0 select, 1 caesar, 2 scytale, 3 zigzag) to bus address
  function automatic logic [7:0] reg_addr(input logic [1:0] idx);
    logic [7:0] a;
    case (idx)
      2'd0:    a = ADDR_SELECT;
      2'd1:    a = ADDR_CAESAR;
      2'd2:    a = ADDR_SCYTALE;
      default: a = ADDR_ZIGZAG;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/decryption_config_master.sv
// Programs select/caesar/scytale/zigzag into the decryption regfile, optionally reads all four back.
// Latency: 2 cycles per access with a 1-cycle responder; start->cfg_done 17 cycles (VERIFY=1), 9 (VERIFY=0).
// Backpressure: each access waits for done, aborting after TIMEOUT_CYCLES; start is ignored while busy.
module decryption_config_master
  import decryption_pkg::*;
#(
  parameter int addr_width     = 8,
  parameter int reg_width      = 16,
  parameter int VERIFY         = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cfg_select,
  input  logic [reg_width-1:0]  cfg_caesar,
  input  logic [reg_width-1:0]  cfg_scytale,
  input  logic [reg_width-1:0]  cfg_zigzag,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_fail,
  output logic [1:0]            err_code,
  output logic [1:0]            err_index,
  output logic [addr_width-1:0] addr,
  output logic                  read,
  output logic                  write,
  output logic [reg_width-1:0]  wdata,
  input  logic [reg_width-1:0]  rdata,
  input  logic                  done,
  input  logic                  error
);

  state_t               state;
  phase_t               phase;
  logic [1:0]           idx;
  logic [3:0]           tmo_cnt;
  logic [1:0]           sel_q;
  logic [reg_width-1:0] caesar_q;
  logic [reg_width-1:0] scytale_q;
  logic [reg_width-1:0] zigzag_q;

  logic [1:0]           nxt_idx;
  phase_t               nxt_phase;
  logic                 seq_last;
  logic [reg_width-1:0] exp_dat;

  // Register index to write data / read-back expectation; select is zero-extended
  function automatic logic [reg_width-1:0] reg_data(
    input logic [1:0]           i,
    input logic [1:0]           sel,
    input logic [reg_width-1:0] c,
    input logic [reg_width-1:0] s,
    input logic [reg_width-1:0] z
  );
    logic [reg_width-1:0] d;
    case (i)
      2'd0:    d = {{(reg_width-2){1'b0}}, sel};
      2'd1:    d = c;
      2'd2:    d = s;
      default: d = z;
    endcase
    return d;
  endfunction

  // Next access: index wraps 3->0 which coincides with the switch to the read-back phase
  always_comb begin
    nxt_idx   = idx + 2'd1;
    nxt_phase = (idx == 2'd3) ? PH_RD : phase;
    seq_last  = (idx == 2'd3) && !((phase == PH_WR) && (VERIFY != 0));
    exp_dat   = reg_data(idx, sel_q, caesar_q, scytale_q, zigzag_q);
  end

  // Sequencer FSM with registered bus strobes and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= PH_WR;
      idx       <= 2'd0;
      tmo_cnt   <= 4'd0;
      sel_q     <= RST_SELECT;
      caesar_q  <= reg_width'(RST_CAESAR);
      scytale_q <= reg_width'(RST_SCYTALE);
      zigzag_q  <= reg_width'(RST_ZIGZAG);
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_fail  <= 1'b0;
      err_code  <= ERR_NONE;
      err_index <= 2'd0;
      addr      <= '0;
      read      <= 1'b0;
      write     <= 1'b0;
      wdata     <= '0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_q     <= cfg_select;
            caesar_q  <= cfg_caesar;
            scytale_q <= cfg_scytale;
            zigzag_q  <= cfg_zigzag;
            cfg_fail  <= 1'b0;
            err_code  <= ERR_NONE;
            err_index <= 2'd0;
            idx       <= 2'd0;
            phase     <= PH_WR;
            busy      <= 1'b1;
            // First write goes out straight from the inputs being latched this edge
            addr      <= addr_width'(reg_addr(2'd0));
            wdata     <= reg_data(2'd0, cfg_select, cfg_caesar, cfg_scytale, cfg_zigzag);
            write     <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          write   <= 1'b0;
          read    <= 1'b0;
          tmo_cnt <= 4'd0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            if (error) begin
              err_code  <= ERR_BUS;
              err_index <= idx;
              state     <= ST_DONE;
            end else if ((phase == PH_RD) && (rdata != exp_dat)) begin
              err_code  <= ERR_VERIFY;
              err_index <= idx;
              state     <= ST_DONE;
            end else if (seq_last) begin
              state <= ST_DONE;
            end else begin
              idx   <= nxt_idx;
              phase <= nxt_phase;
              addr  <= addr_width'(reg_addr(nxt_idx));
              wdata <= reg_data(nxt_idx, sel_q, caesar_q, scytale_q, zigzag_q);
              write <= (nxt_phase == PH_WR);
              read  <= (nxt_phase == PH_RD);
              state <= ST_ISSUE;
            end
          end else if (tmo_cnt == 4'(TIMEOUT_CYCLES - 1)) begin
            err_code  <= ERR_TIMEOUT;
            err_index <= idx;
            state     <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          cfg_done <= 1'b1;
          cfg_fail <= (err_code != ERR_NONE);
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decryption_config_master.sv
// Bench for decryption_config_master with a behavioural register-file responder.
// Responder answers one cycle after each strobe; faults are injected per address.
// Expected bus accesses are queued at start and checked as the DUT issues them.
module tb_decryption_config_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  cfg_select = 2'd0;
  logic [15:0] cfg_caesar = 16'h0;
  logic [15:0] cfg_scytale = 16'h0;
  logic [15:0] cfg_zigzag = 16'h0;
  logic        busy, cfg_done, cfg_fail;
  logic [1:0]  err_code, err_index;
  logic [7:0]  addr;
  logic        read, write;
  logic [15:0] wdata;
  logic [15:0] rdata = 16'h0;
  logic        done = 1'b0;
  logic        error = 1'b0;

  int total = 0;
  int bad = 0;
  int done_pulses = 0;

  typedef struct packed {
    logic        wr;
    logic [7:0]  a;
    logic [15:0] d;
  } acc_t;
  acc_t exp_q[$];

  logic [15:0] mem [256];
  bit          err_en = 1'b0;
  logic [7:0]  err_addr = 8'h00;
  bit          corrupt_en = 1'b0;
  logic [7:0]  corrupt_addr = 8'h00;
  bit          no_done = 1'b0;

  decryption_config_master dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_select(cfg_select), .cfg_caesar(cfg_caesar),
    .cfg_scytale(cfg_scytale), .cfg_zigzag(cfg_zigzag),
    .busy(busy), .cfg_done(cfg_done), .cfg_fail(cfg_fail),
    .err_code(err_code), .err_index(err_index),
    .addr(addr), .read(read), .write(write), .wdata(wdata),
    .rdata(rdata), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Register-file responder: done one cycle after a strobe, optional faults
  always @(posedge clk) begin
    done  <= (read || write) && !no_done;
    error <= write && err_en && (addr == err_addr) && !no_done;
    rdata <= 16'h0;
    if (read)
      rdata <= (corrupt_en && addr == corrupt_addr) ? 16'h0007 : mem[addr];
    if (write && !no_done && !(err_en && addr == err_addr))
      mem[addr] <= wdata;
  end

  // Bus monitor: every strobe must match the next expected access
  always @(negedge clk) begin
    acc_t e;
    if (cfg_done) done_pulses++;
    if (read || write) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL bus_access: unexpected rd=%0b wr=%0b addr=%h wdata=%h, none expected",
                 read, write, addr, wdata);
      end else begin
        e = exp_q.pop_front();
        if ((read && write) || write !== e.wr || read !== !e.wr || addr !== e.a ||
            (write && wdata !== e.d)) begin
          bad++;
          $display("FAIL bus_access: got rd=%0b wr=%0b addr=%h wdata=%h, want wr=%0b addr=%h wdata=%h",
                   read, write, addr, wdata, e.wr, e.a, e.d);
        end
      end
    end
  end

  task automatic set_cfg(input logic [1:0] s, input logic [15:0] c, input logic [15:0] sc,
                         input logic [15:0] z);
    cfg_select  = s;
    cfg_caesar  = c;
    cfg_scytale = sc;
    cfg_zigzag  = z;
  endtask

  // Queue the first n accesses of a full write-then-read sequence
  task automatic push_seq(input logic [1:0] s, input logic [15:0] c, input logic [15:0] sc,
                          input logic [15:0] z, input int n);
    acc_t       a;
    logic [7:0] ad [4];
    logic [15:0] dt [4];
    ad[0] = 8'h00; ad[1] = 8'h10; ad[2] = 8'h12; ad[3] = 8'h14;
    dt[0] = {14'b0, s}; dt[1] = c; dt[2] = sc; dt[3] = z;
    for (int i = 0; i < n; i++) begin
      a.wr = (i < 4);
      a.a  = ad[i % 4];
      a.d  = dt[i % 4];
      exp_q.push_back(a);
    end
  endtask

  // Pulse start, then count edges after the sampling edge until cfg_done (bounded)
  task automatic run_seq(input bit disturb, output int lat, output bit got);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (lat < 200 && !got) begin
      @(posedge clk);
      lat++;
      #1;
      if (disturb) begin
        start = (lat == 3 || lat == 6 || lat == 10);
        if (lat == 2) set_cfg(2'd1, 16'hDEAD, 16'hBEEF, 16'hCAFE);
      end
      got = cfg_done;
    end
    start = 1'b0;
  endtask

  task automatic settle_and_check_queue(input string name);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_queue: %0d expected accesses never issued, want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, cfg_done, cfg_fail, read, write} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: busy/done/fail/rd/wr=%b want 00000",
               {busy, cfg_done, cfg_fail, read, write});
    end
    total++;
    if ({err_code, err_index} !== 4'b0) begin
      bad++;
      $display("FAIL reset_err: code=%0d index=%0d want 0 0", err_code, err_index);
    end
    total++;
    if (addr !== 8'h00 || wdata !== 16'h0) begin
      bad++;
      $display("FAIL reset_bus: addr=%h wdata=%h want 00 0000", addr, wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int lat;
    bit got;
    set_cfg(2'd2, 16'h0003, 16'h0404, 16'h0005);
    push_seq(2'd2, 16'h0003, 16'h0404, 16'h0005, 8);
    run_seq(1'b0, lat, got);
    total++;
    if (!got || lat != 17) begin
      bad++;
      $display("FAIL nominal_latency: got=%0b lat=%0d want cfg_done at 17", got, lat);
    end
    total++;
    if (cfg_fail !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL nominal_status: fail=%0b code=%0d busy=%0b want 0 0 0", cfg_fail, err_code, busy);
    end
    @(posedge clk);
    #1;
    total++;
    if (cfg_done !== 1'b0) begin
      bad++;
      $display("FAIL nominal_pulse: cfg_done=%0b one cycle later, want 0", cfg_done);
    end
    total++;
    if ({mem[8'h00], mem[8'h10], mem[8'h12], mem[8'h14]} !== {16'h0002, 16'h0003, 16'h0404, 16'h0005}) begin
      bad++;
      $display("FAIL nominal_regfile: %h %h %h %h want 0002 0003 0404 0005",
               mem[8'h00], mem[8'h10], mem[8'h12], mem[8'h14]);
    end
    settle_and_check_queue("nominal");
  endtask

  task automatic test_bus_error();
    int lat;
    bit got;
    err_en = 1'b1;
    err_addr = 8'h12;
    set_cfg(2'd1, 16'h0011, 16'h0022, 16'h0AAA);
    push_seq(2'd1, 16'h0011, 16'h0022, 16'h0AAA, 3);
    run_seq(1'b0, lat, got);
    total++;
    if (!got || cfg_fail !== 1'b1 || err_code !== 2'd1 || err_index !== 2'd2) begin
      bad++;
      $display("FAIL bus_error_status: got=%0b fail=%0b code=%0d idx=%0d want 1 1 1 2",
               got, cfg_fail, err_code, err_index);
    end
    total++;
    if (mem[8'h14] !== 16'h0005) begin
      bad++;
      $display("FAIL bus_error_zigzag: zigzag=%h want 0005 (untouched)", mem[8'h14]);
    end
    err_en = 1'b0;
    settle_and_check_queue("bus_error");
    total++;
    if (cfg_fail !== 1'b1 || err_code !== 2'd1) begin
      bad++;
      $display("FAIL bus_error_hold: fail=%0b code=%0d want held 1 1", cfg_fail, err_code);
    end
  endtask

  task automatic test_verify_mismatch();
    int lat;
    bit got;
    corrupt_en = 1'b1;
    corrupt_addr = 8'h10;
    set_cfg(2'd2, 16'h0003, 16'h0404, 16'h0005);
    push_seq(2'd2, 16'h0003, 16'h0404, 16'h0005, 6);
    run_seq(1'b0, lat, got);
    total++;
    if (!got || cfg_fail !== 1'b1 || err_code !== 2'd2 || err_index !== 2'd1) begin
      bad++;
      $display("FAIL verify_status: got=%0b fail=%0b code=%0d idx=%0d want 1 1 2 1",
               got, cfg_fail, err_code, err_index);
    end
    corrupt_en = 1'b0;
    settle_and_check_queue("verify");
  endtask

  task automatic test_timeout();
    int lat;
    bit got;
    no_done = 1'b1;
    set_cfg(2'd3, 16'h0001, 16'h0002, 16'h0003);
    push_seq(2'd3, 16'h0001, 16'h0002, 16'h0003, 1);
    run_seq(1'b0, lat, got);
    total++;
    if (!got || lat != 17) begin
      bad++;
      $display("FAIL timeout_latency: got=%0b lat=%0d want cfg_done at 17", got, lat);
    end
    total++;
    if (cfg_fail !== 1'b1 || err_code !== 2'd3 || err_index !== 2'd0) begin
      bad++;
      $display("FAIL timeout_status: fail=%0b code=%0d idx=%0d want 1 3 0", cfg_fail, err_code, err_index);
    end
    no_done = 1'b0;
    settle_and_check_queue("timeout");
  endtask

  task automatic test_back_to_back();
    int lat;
    bit got;
    int p0;
    p0 = done_pulses;
    set_cfg(2'd3, 16'h0101, 16'h0202, 16'h0303);
    push_seq(2'd3, 16'h0101, 16'h0202, 16'h0303, 8);
    run_seq(1'b1, lat, got);
    total++;
    if (!got || lat != 17 || cfg_fail !== 1'b0) begin
      bad++;
      $display("FAIL b2b_status: got=%0b lat=%0d fail=%0b want 1 17 0", got, lat, cfg_fail);
    end
    total++;
    if ({mem[8'h00], mem[8'h10], mem[8'h12], mem[8'h14]} !== {16'h0003, 16'h0101, 16'h0202, 16'h0303}) begin
      bad++;
      $display("FAIL b2b_regfile: %h %h %h %h want 0003 0101 0202 0303",
               mem[8'h00], mem[8'h10], mem[8'h12], mem[8'h14]);
    end
    settle_and_check_queue("b2b");
    total++;
    if (done_pulses - p0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_single: cfg_done pulses=%0d busy=%0b want 1 0", done_pulses - p0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit got;
    int p0;
    set_cfg(2'd1, 16'h0055, 16'h0066, 16'h0077);
    push_seq(2'd1, 16'h0055, 16'h0066, 16'h0077, 2);
    p0 = done_pulses;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({read, write, busy} !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid_async: rd/wr/busy=%b want 000 without a clock edge", {read, write, busy});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    settle_and_check_queue("rst_mid");
    total++;
    if (done_pulses != p0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_nodone: cfg_done pulses=%0d busy=%0b want 0 0", done_pulses - p0, busy);
    end
    set_cfg(2'd0, 16'h1234, 16'h0F0F, 16'h0009);
    push_seq(2'd0, 16'h1234, 16'h0F0F, 16'h0009, 8);
    run_seq(1'b0, lat, got);
    total++;
    if (!got || lat != 17 || cfg_fail !== 1'b0 || err_code !== 2'd0) begin
      bad++;
      $display("FAIL rst_mid_rerun: got=%0b lat=%0d fail=%0b code=%0d want 1 17 0 0",
               got, lat, cfg_fail, err_code);
    end
    total++;
    if (mem[8'h10] !== 16'h1234 || mem[8'h14] !== 16'h0009) begin
      bad++;
      $display("FAIL rst_mid_regfile: caesar=%h zigzag=%h want 1234 0009", mem[8'h10], mem[8'h14]);
    end
    settle_and_check_queue("rerun");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_nominal();
    test_bus_error();
    test_verify_mismatch();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
